// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide unit and the control unit.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} md_state_t;

  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;

  localparam logic [7:0] DIV_ZERO_VEC = 8'd255;
endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit / datapath and the mult/div unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start_mult, start_div, op_a, op_b,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  start_mult, start_div, op_a, op_b,
                  output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate: magnitude when neg=sign bit, sign fix otherwise.
module md_abs_neg #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);
  assign res = neg ? (~val + WIDTH'(1)) : val;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) producing HI/LO.
module mult_div_unit import cpu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d, mcand_q, mcand_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]   mc_ext, sum, acc_sh;
  logic [WIDTH-1:0] q_sh, rem_st, quo_st;
  logic             q1_sh;
  logic [WIDTH:0]   shifted, trial;

  md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.val(md.op_a), .neg(md.op_a[WIDTH-1]), .res(mag_a));
  md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.val(md.op_b), .neg(md.op_b[WIDTH-1]), .res(mag_b));
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.val(quo_st),  .neg(qneg_q),           .res(quo_fix));
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.val(rem_st),  .neg(rneg_q),           .res(rem_fix));

  // One Booth step and one restoring step, evaluated every cycle.
  always_comb begin
    mc_ext = {mcand_q[WIDTH-1], mcand_q};
    sum    = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + mc_ext;
      2'b10:   sum = acc_q - mc_ext;
      default: sum = acc_q;
    endcase
    acc_sh  = {sum[WIDTH], sum[WIDTH:1]};
    q_sh    = {sum[0], q_q[WIDTH-1:1]};
    q1_sh   = q_q[0];

    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_st  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_st  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;
    acc_d   = acc_q;    q_d     = q_q;    q1_d   = q1_q;   mcand_d = mcand_q;
    rem_d   = rem_q;    quo_d   = quo_q;  dvs_d  = dvs_q;
    qneg_d  = qneg_q;   rneg_d  = rneg_q;
    hi_d    = hi_q;     lo_d    = lo_q;
    busy_d  = busy_q;   done_d  = 1'b0;   dz_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (md.start_mult) begin
          state_d = MULT;  cnt_d = '0;  busy_d = 1'b1;
          acc_d   = '0;    q_d   = md.op_b;  q1_d = 1'b0;  mcand_d = md.op_a;
        end else if (md.start_div) begin
          if (md.op_b != '0) begin
            state_d = DIV;  cnt_d = '0;  busy_d = 1'b1;
            rem_d   = '0;   quo_d = mag_a;  dvs_d = mag_b;
            qneg_d  = md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1];
            rneg_d  = md.op_a[WIDTH-1];
          end else begin
            dz_d = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d = acc_sh;  q_d = q_sh;  q1_d = q1_sh;
        if (cnt_q == LAST) begin
          hi_d = acc_sh[WIDTH-1:0];  lo_d = q_sh;
          done_d = 1'b1;  state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        rem_d = rem_st;  quo_d = quo_st;
        if (cnt_q == LAST) begin
          hi_d = rem_fix;  lo_d = quo_fix;
          done_d = 1'b1;  state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;  busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q <= '0;
      acc_q   <= '0;    q_q   <= '0;  q1_q  <= 1'b0;  mcand_q <= '0;
      rem_q   <= '0;    quo_q <= '0;  dvs_q <= '0;
      qneg_q  <= 1'b0;  rneg_q <= 1'b0;
      hi_q    <= '0;    lo_q  <= '0;
      busy_q  <= 1'b0;  done_q <= 1'b0;  dz_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      acc_q   <= acc_d;    q_q   <= q_d;    q1_q  <= q1_d;  mcand_q <= mcand_d;
      rem_q   <= rem_d;    quo_q <= quo_d;  dvs_q <= dvs_d;
      qneg_q  <= qneg_d;   rneg_q <= rneg_d;
      hi_q    <= hi_d;     lo_q  <= lo_d;
      busy_q  <= busy_d;   done_q <= done_d;  dz_q <= dz_d;
    end
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.div_zero = dz_q;
endmodule
